vx_serial_divide: RTL and testbench

Multi-lane, iterative radix-2 integer divider with valid/ready handshakes, a signed/unsigned mode, and RISC-V divide-by-zero and overflow semantics. It is the handshaked successor to the fixed-latency pipelined divider and serves as the DIV/REM back end of the ALU. It trades throughput for area: all lanes share one control FSM and compute one quotient bit per cycle.

---
 rtl/vx_serial_divide_pkg.sv | 12 +
 rtl/vx_serial_divide_if.sv | 18 +
 rtl/vx_div_lane.sv | 49 ++++
 rtl/vx_serial_divide.sv | 72 +++++++
 tb/tb_vx_serial_divide.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/vx_serial_divide_pkg.sv
// vx_div_pkg: shared state encoding, counter width and sign helpers for the serial divider
package vx_div_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   localparam int MAX_W = 64;
   localparam int CNT_W = $clog2(MAX_W + 1);
   function automatic logic [MAX_W-1:0] neg_val(input logic [MAX_W-1:0] v);
      return ~v + MAX_W'(1);
   endfunction
   function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] v, input logic s);
      return s ? neg_val(v) : v;
   endfunction
endpackage

// File: rtl/vx_serial_divide_if.sv
// vx_serial_divide_if: request/result handshake bundle of the serial divider
interface vx_serial_divide_if #(
   parameter int WIDTH = 32,
   parameter int LANES = 1,
   parameter int TAG_WIDTH = 8
);
   logic in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [TAG_WIDTH-1:0] in_tag, out_tag;
   logic [LANES*WIDTH-1:0] numer, denom, quotient, remainder;
   modport master (
      output in_valid, in_signed, in_tag, numer, denom, out_ready,
      input in_ready, out_valid, out_tag, quotient, remainder
   );
   modport slave (
      input in_valid, in_signed, in_tag, numer, denom, out_ready,
      output in_ready, out_valid, out_tag, quotient, remainder
   );
endinterface

// File: rtl/vx_div_lane.sv
// vx_div_lane: one restoring-division lane with sign and divide-by-zero fix-up
module vx_div_lane import vx_div_pkg::*; #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             aclr,
   input  logic             load,
   input  logic             step,
   input  logic             fix,
   input  logic             in_signed,
   input  logic             mode,
   input  logic [WIDTH-1:0] numer,
   input  logic [WIDTH-1:0] denom,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);
   logic sn, sd;
   logic [WIDTH-1:0] dvd, dsr, rem, raw_n, raw_d;
   logic [WIDTH:0] sh, trial;
   assign sh = {rem, dvd[WIDTH-1]};
   assign trial = sh - {1'b0, dsr};
   // latch magnitudes on accept, shift in one quotient bit per step, then apply signs into the outputs
   always_ff @(posedge clock or posedge aclr)
      if (aclr) begin
         sn <= 1'b0;
         sd <= 1'b0;
         dvd <= '0;
         dsr <= '0;
         rem <= '0;
         raw_n <= '0;
         raw_d <= '0;
         quotient <= '0;
         remainder <= '0;
      end else if (load) begin
         sn <= numer[WIDTH-1];
         sd <= denom[WIDTH-1];
         dvd <= WIDTH'(abs_val(MAX_W'(numer), in_signed & numer[WIDTH-1]));
         dsr <= WIDTH'(abs_val(MAX_W'(denom), in_signed & denom[WIDTH-1]));
         rem <= '0;
         raw_n <= numer;
         raw_d <= denom;
      end else if (step) begin
         rem <= trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
         dvd <= {dvd[WIDTH-2:0], ~trial[WIDTH]};
      end else if (fix) begin
         quotient <= raw_d == '0 ? '1 : (mode & (sn ^ sd)) ? WIDTH'(neg_val(MAX_W'(dvd))) : dvd;
         remainder <= raw_d == '0 ? raw_n : (mode & sn) ? WIDTH'(neg_val(MAX_W'(rem))) : rem;
      end
endmodule

// File: rtl/vx_serial_divide.sv
// vx_serial_divide: multi-lane iterative radix-2 divider with valid/ready handshakes
module vx_serial_divide import vx_div_pkg::*; #(
   parameter int WIDTH = 32,
   parameter int LANES = 1,
   parameter int TAG_WIDTH = 8
) (
   input logic              clock,
   input logic              aclr,
   input logic              clken,
   vx_serial_divide_if.slave bus
);
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [TAG_WIDTH-1:0] tag_q, out_tag;
   logic [LANES*WIDTH-1:0] q_all, r_all;
   logic mode, acc, step, fix;
   assign bus.in_ready = state == IDLE && clken;
   assign bus.out_valid = state == DONE;
   assign bus.out_tag = out_tag;
   assign bus.quotient = q_all;
   assign bus.remainder = r_all;
   assign acc = bus.in_valid & bus.in_ready;
   assign step = clken && state == CALC;
   assign fix = clken && state == FIX;
   // next state, every transition gated by the global enable
   always_comb begin
      state_nx = state;
      if (clken)
         unique case (state)
            IDLE: state_nx = bus.in_valid ? CALC : IDLE;
            CALC: state_nx = cnt == CNT_W'(1) ? FIX : CALC;
            FIX:  state_nx = DONE;
            DONE: state_nx = bus.out_ready ? IDLE : DONE;
            default: state_nx = IDLE;
         endcase
   end
   // state register
   always_ff @(posedge clock or posedge aclr)
      if (aclr) state <= IDLE;
      else state <= state_nx;
   // bit counter, request tag/mode capture and result tag
   always_ff @(posedge clock or posedge aclr)
      if (aclr) begin
         cnt <= '0;
         tag_q <= '0;
         mode <= 1'b0;
         out_tag <= '0;
      end else if (acc) begin
         cnt <= CNT_W'(WIDTH);
         tag_q <= bus.in_tag;
         mode <= bus.in_signed;
      end else if (step) begin
         cnt <= cnt - CNT_W'(1);
      end else if (fix) begin
         out_tag <= tag_q;
      end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vx_div_lane #(.WIDTH(WIDTH)) u_lane (
         .clock     (clock),
         .aclr      (aclr),
         .load      (acc),
         .step      (step),
         .fix       (fix),
         .in_signed (bus.in_signed),
         .mode      (mode),
         .numer     (bus.numer[i*WIDTH +: WIDTH]),
         .denom     (bus.denom[i*WIDTH +: WIDTH]),
         .quotient  (q_all[i*WIDTH +: WIDTH]),
         .remainder (r_all[i*WIDTH +: WIDTH])
      );
   end
endmodule

// File: tb/tb_vx_serial_divide.sv
// tb_vx_serial_divide: directed and random checks of the 4-lane 32-bit serial divider
module tb_vx_serial_divide;
   localparam int W = 32;
   localparam int L = 4;
   logic clock = 1'b0;
   logic aclr = 1'b1;
   logic clken = 1'b1;
   int errors = 0;
   int checks = 0;
   vx_serial_divide_if #(.WIDTH(W), .LANES(L), .TAG_WIDTH(8)) bus ();
   vx_serial_divide #(.WIDTH(W), .LANES(L), .TAG_WIDTH(8)) dut (
      .clock (clock),
      .aclr  (aclr),
      .clken (clken),
      .bus   (bus)
   );
   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic sg, input logic [31:0] n, input logic [31:0] d,
                                   output logic [31:0] q, output logic [31:0] r);
      if (d == 0) begin
         q = '1;
         r = n;
      end else if (!sg) begin
         q = n / d;
         r = n % d;
      end else if (n == 32'h8000_0000 && d == 32'hffff_ffff) begin
         q = n;
         r = 0;
      end else begin
         q = $signed(n) / $signed(d);
         r = $signed(n) % $signed(d);
      end
   endfunction

   task automatic run(input string nm, input logic sg, input logic [7:0] tag,
                      input logic [127:0] n, input logic [127:0] d, input int stall_at, input int bp);
      logic [127:0] eq, er;
      logic [31:0] q, r;
      logic hi, stable;
      int lat;
      for (int k = 0; k < L; k++) begin
         ref_div(sg, n[k*32 +: 32], d[k*32 +: 32], q, r);
         eq[k*32 +: 32] = q;
         er[k*32 +: 32] = r;
      end
      bus.out_ready = 1'b0;
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_signed = sg;
      bus.in_tag = tag;
      bus.numer = n;
      bus.denom = d;
      chk({nm, ".ready_idle"}, bus.in_ready, 1);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      bus.numer = '0;
      bus.denom = '0;
      bus.in_tag = '0;
      lat = 0;
      hi = 1'b0;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(negedge clock);
         clken = !(stall_at >= 0 && lat >= stall_at && lat < stall_at + 3);
         hi |= bus.in_ready;
         @(posedge clock);
         #1;
         lat++;
      end
      clken = 1'b1;
      chk({nm, ".latency"}, lat, stall_at >= 0 ? 36 : 33);
      chk({nm, ".ready_busy"}, hi, 0);
      chk({nm, ".quotient"}, bus.quotient, eq);
      chk({nm, ".remainder"}, bus.remainder, er);
      chk({nm, ".tag"}, bus.out_tag, tag);
      stable = 1'b1;
      repeat (bp) begin
         @(posedge clock);
         #1;
         stable &= bus.out_valid === 1'b1 && bus.in_ready === 1'b0 &&
                   bus.quotient === eq && bus.remainder === er && bus.out_tag === tag;
      end
      chk({nm, ".hold"}, stable, 1);
      @(negedge clock);
      bus.out_ready = 1'b1;
      @(posedge clock);
      #1;
      chk({nm, ".drained"}, bus.out_valid, 0);
      chk({nm, ".ready_again"}, bus.in_ready, 1);
      bus.out_ready = 1'b0;
   endtask

   function automatic logic [127:0] pack(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] e);
      return {e, c, b, a};
   endfunction

   initial begin
      logic seen;
      logic [127:0] n, d;
      bus.in_valid = 1'b0;
      bus.in_signed = 1'b0;
      bus.in_tag = '0;
      bus.numer = '0;
      bus.denom = '0;
      bus.out_ready = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      chk("reset.valid", bus.out_valid, 0);
      chk("reset.quotient", bus.quotient, 0);
      chk("reset.remainder", bus.remainder, 0);
      chk("reset.tag", bus.out_tag, 0);
      @(negedge clock);
      aclr = 1'b0;
      run("u56_11", 1'b0, 8'h11, pack(56, $urandom, $urandom, $urandom), pack(11, $urandom, 3, 1), -1, 0);
      run("signed_mix", 1'b1, 8'h22, pack(-56, 56, -56, 32'h8000_0000), pack(11, -11, -11, 32'hffff_ffff), -1, 5);
      run("div0", 1'b0, 8'h33, pack(56, 0, 32'hffff_ffff, 9), pack(0, 0, 0, 0), -1, 1);
      run("sdiv0", 1'b1, 8'h44, pack(-7, 7, 32'h8000_0000, -1), pack(0, 0, 0, 0), -1, 0);
      run("lanes", 1'b0, 8'h5a, pack(100, 5, 0, 32'hffff_ffff), pack(7, 0, 3, 1), 10, 2);
      @(negedge clock);
      bus.in_valid = 1'b1;
      bus.in_signed = 1'b0;
      bus.in_tag = 8'h66;
      bus.numer = pack(1000, 2000, 3000, 4000);
      bus.denom = pack(3, 7, 11, 13);
      @(posedge clock);
      #1;
      bus.in_valid = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      aclr = 1'b1;
      #1;
      chk("abort.valid", bus.out_valid, 0);
      chk("abort.quotient", bus.quotient, 0);
      chk("abort.remainder", bus.remainder, 0);
      chk("abort.tag", bus.out_tag, 0);
      @(negedge clock);
      aclr = 1'b0;
      bus.out_ready = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clock);
         #1;
         seen |= bus.out_valid;
      end
      chk("abort.no_result", seen, 0);
      run("after_abort", 1'b1, 8'h77, pack(-1000, 2000, 12345, -99), pack(3, -7, 1, 10), -1, 0);
      for (int t = 0; t < 10; t++) begin
         for (int k = 0; k < L; k++) begin
            n[k*32 +: 32] = $urandom_range(0, 1) ? $urandom : $urandom_range(0, 500);
            d[k*32 +: 32] = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(0, 2) == 0 ? $urandom : $urandom_range(1, 40);
         end
         run($sformatf("rand%0d", t), 1'($urandom_range(0, 1)), 8'($urandom), n, d,
             $urandom_range(0, 1) ? int'($urandom_range(0, 25)) : -1, $urandom_range(0, 3));
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
